vx_lsu_req_arbiter: RTL and testbench

// - Shares one data-cache request/response port among NUM_INPUTS LSU-side requesters.
// - Uses round-robin arbitration, one registered output stage, and tag-based response routing.
// - Caps outstanding reads per requester.
// - Sits between the LSU blocks and the memory unit inside the core; drives the busy/drain indication.

---
 rtl/vx_lsu_req_arbiter_pkg.sv | 17 +
 rtl/vx_rr_grant.sv | 39 +++
 rtl/vx_lsu_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vx_lsu_req_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_lsu_req_arbiter_pkg.sv
// rtl/vx_lsu_req_arbiter_pkg.sv - shared sizing helpers for the LSU request arbiter
// Purpose: index-field sizing function and core-level tag width constant.
// Contents:
//   lsu_arb_sel_bits(n)   bits needed for a requester index (at least 1)
//   LSU_ARB_TAG_WIDTH     memory-side tag width for the core-level instance
package vx_lsu_req_arbiter_pkg;

    // A single requester still carries a 1-bit index so the tag layout never collapses.
    function automatic int lsu_arb_sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LSU_ARB_NUM_INPUTS    = 2;
    localparam int LSU_ARB_REQ_TAG_WIDTH = 8;
    localparam int LSU_ARB_TAG_WIDTH     = LSU_ARB_REQ_TAG_WIDTH + lsu_arb_sel_bits(LSU_ARB_NUM_INPUTS);

endpackage

// File: rtl/vx_rr_grant.sv
// rtl/vx_rr_grant.sv - combinational one-hot round-robin pick
// Purpose: picks the first set bit of valid at or after ptr, wrapping around.
// Ports:
//   valid      in   NUM_INPUTS   candidate mask
//   ptr        in   SEL_BITS     highest-priority index (held by the parent)
//   grant      out  NUM_INPUTS   one-hot pick, zero when nothing is valid
//   grant_idx  out  SEL_BITS     binary index of the pick
//   any        out  1            a pick was made
module vx_rr_grant #(
    parameter int NUM_INPUTS = 2,
    parameter int SEL_BITS   = 1
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [SEL_BITS-1:0]   ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [SEL_BITS-1:0]   grant_idx,
    output logic                  any
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            // ptr is always below NUM_INPUTS, so one conditional subtract wraps it.
            j = int'(ptr) + k;
            if (j >= NUM_INPUTS) begin
                j = j - NUM_INPUTS;
            end
            if (!any && valid[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SEL_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/vx_lsu_req_arbiter.sv
// rtl/vx_lsu_req_arbiter.sv - round-robin LSU to data-cache request arbiter
// Purpose: shares one memory request/response port among NUM_INPUTS requesters,
// with a single registered request stage, tag-based response routing and a cap
// on outstanding reads per requester.
// Ports:
//   clk, reset                        core clock, synchronous active-high reset
//   req_valid_in/rw/addr/data/tag     packed per-requester requests
//   req_ready_in                      one-hot accept (or zero)
//   rsp_valid_out/data/tag            routed response, data broadcast
//   rsp_ready_out                     per-requester response ready
//   mem_req_*                         registered memory request, tag = {req tag, index}
//   mem_rsp_*                         memory response, index taken from tag LSBs
//   busy                              reads outstanding or request stage full
module vx_lsu_req_arbiter
    import vx_lsu_req_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS    = 2,
    parameter int  ADDR_WIDTH    = 32,
    parameter int  DATA_WIDTH    = 64,
    parameter int  TAG_WIDTH     = 8,
    parameter int  MAX_PENDING   = 16,
    localparam int SEL_BITS      = lsu_arb_sel_bits(NUM_INPUTS),
    localparam int CNT_BITS      = $clog2(MAX_PENDING + 1),
    localparam int MEM_TAG_WIDTH = TAG_WIDTH + SEL_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            req_valid_in,
    input  logic [NUM_INPUTS-1:0]            req_rw_in,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req_data_in,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  req_tag_in,
    output logic [NUM_INPUTS-1:0]            req_ready_in,
    output logic [NUM_INPUTS-1:0]            rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic [TAG_WIDTH-1:0]             rsp_tag_out,
    input  logic [NUM_INPUTS-1:0]            rsp_ready_out,
    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [MEM_TAG_WIDTH-1:0]         mem_req_tag,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    input  logic [MEM_TAG_WIDTH-1:0]         mem_rsp_tag,
    output logic                             mem_rsp_ready,
    output logic                             busy
);

    logic [NUM_INPUTS-1:0]    eligible;
    logic [NUM_INPUTS-1:0]    grant;
    logic [NUM_INPUTS-1:0]    pend_nz;
    logic [SEL_BITS-1:0]      grant_idx;
    logic [SEL_BITS-1:0]      rr_ptr;
    logic [SEL_BITS-1:0]      next_ptr;
    logic                     grant_any;
    logic                     can_load;
    logic                     do_grant;
    logic [SEL_BITS-1:0]      rsp_idx;
    logic                     rsp_fire;

    logic                     sel_rw;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [MEM_TAG_WIDTH-1:0] sel_tag;

    // The stage can take a new request when empty or when its current one leaves this cycle.
    assign can_load     = !mem_req_valid || mem_req_ready;
    assign do_grant     = can_load && grant_any;
    assign req_ready_in = can_load ? grant : '0;
    assign next_ptr     = (grant_idx == SEL_BITS'(NUM_INPUTS - 1)) ? '0 : grant_idx + SEL_BITS'(1);

    vx_rr_grant #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_BITS   (SEL_BITS)
    ) u_rr_grant (
        .valid      (eligible),
        .ptr        (rr_ptr),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    // Mux driven by the one-hot grant so no index ever exceeds the packed range.
    always_comb begin
        sel_rw   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                sel_rw   = req_rw_in[i];
                sel_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag  = {req_tag_in[i*TAG_WIDTH +: TAG_WIDTH], SEL_BITS'(i)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            rr_ptr        <= '0;
        end else if (can_load) begin
            // A fire without a new grant empties the stage; with one it refills it.
            mem_req_valid <= grant_any;
            if (grant_any) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Payload needs no reset: it is only observed while mem_req_valid is set.
    always_ff @(posedge clk) begin
        if (do_grant) begin
            mem_req_rw   <= sel_rw;
            mem_req_addr <= sel_addr;
            mem_req_data <= sel_data;
            mem_req_tag  <= sel_tag;
        end
    end

    assign rsp_idx      = mem_rsp_tag[SEL_BITS-1:0];
    assign rsp_tag_out  = mem_rsp_tag[MEM_TAG_WIDTH-1:SEL_BITS];
    assign rsp_data_out = mem_rsp_data;

    always_comb begin
        rsp_valid_out = '0;
        mem_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_idx == SEL_BITS'(i)) begin
                rsp_valid_out[i] = mem_rsp_valid;
                mem_rsp_ready    = rsp_ready_out[i];
            end
        end
    end

    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_pend
        logic [CNT_BITS-1:0] count;
        logic                inc;
        logic                dec;

        // Writes bypass the cap; only reads wait for a free slot.
        assign eligible[i] = req_valid_in[i] && !(!req_rw_in[i] && count == CNT_BITS'(MAX_PENDING));
        assign inc         = do_grant && grant[i] && !req_rw_in[i];
        assign dec         = rsp_fire && rsp_valid_out[i];
        assign pend_nz[i]  = (count != '0);

        always_ff @(posedge clk) begin
            if (reset) begin
                count <= '0;
            end else if (inc && !dec) begin
                count <= count + CNT_BITS'(1);
            end else if (dec && !inc) begin
                count <= count - CNT_BITS'(1);
            end
        end

        always @(posedge clk) begin
            if (!reset) begin
                assert (!(dec && count == '0));
                assert (!(inc && count == CNT_BITS'(MAX_PENDING)));
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && mem_rsp_valid) begin
            assert (int'(rsp_idx) < NUM_INPUTS);
        end
    end

    assign busy = mem_req_valid || (|pend_nz);

endmodule

// File: tb/tb_vx_lsu_req_arbiter.sv
// tb/tb_vx_lsu_req_arbiter.sv - scoreboard bench for the LSU request arbiter
module tb_vx_lsu_req_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int TW  = 8;
    localparam int MP  = 2;
    localparam int SB  = 1;
    localparam int MTW = TW + SB;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid_in, req_rw_in, req_ready_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N*DW-1:0]   req_data_in;
    logic [N*TW-1:0]   req_tag_in;
    logic [N-1:0]      rsp_valid_out, rsp_ready_out;
    logic [DW-1:0]     rsp_data_out;
    logic [TW-1:0]     rsp_tag_out;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic [MTW-1:0]    mem_req_tag;
    logic              mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0]     mem_rsp_data;
    logic [MTW-1:0]    mem_rsp_tag;
    logic              busy;

    always #5 clk = ~clk;

    vx_lsu_req_arbiter #(
        .NUM_INPUTS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .TAG_WIDTH (TW), .MAX_PENDING (MP)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid_in (req_valid_in), .req_rw_in (req_rw_in),
        .req_addr_in (req_addr_in), .req_data_in (req_data_in),
        .req_tag_in (req_tag_in), .req_ready_in (req_ready_in),
        .rsp_valid_out (rsp_valid_out), .rsp_data_out (rsp_data_out),
        .rsp_tag_out (rsp_tag_out), .rsp_ready_out (rsp_ready_out),
        .mem_req_valid (mem_req_valid), .mem_req_rw (mem_req_rw),
        .mem_req_addr (mem_req_addr), .mem_req_data (mem_req_data),
        .mem_req_tag (mem_req_tag), .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid), .mem_rsp_data (mem_rsp_data),
        .mem_rsp_tag (mem_rsp_tag), .mem_rsp_ready (mem_rsp_ready),
        .busy (busy)
    );

    typedef struct {
        logic           rw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [MTW-1:0] tag;
    } mreq_t;

    typedef struct {
        int             idx;
        logic [TW-1:0]  tag;
        logic [DW-1:0]  data;
        logic           ready;
    } rsp_t;

    mreq_t          exp_q[$];    // requests granted and not yet fired (stage contents)
    rsp_t           rsp_q[$];    // responses driven this cycle, awaiting the monitor
    logic [MTW-1:0] mem_out[$];  // reads accepted by memory, awaiting a response
    int             pend[N];
    int             ptr;
    int             total = 0;
    int             bad = 0;
    bit             mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input logic [N-1:0] v, input logic [N-1:0] rw,
                         input bit mrdy, input bit rsp_en, input logic [N-1:0] rrdy);
        int           k;
        int           g;
        int           ridx;
        bit           any_p;
        logic [N-1:0] eg;
        logic [N-1:0] exp_rdy;
        rsp_t         r;
        mreq_t        e;
        @(negedge clk);
        reset         = rst;
        req_valid_in  = v;
        req_rw_in     = rw;
        mem_req_ready = mrdy;
        rsp_ready_out = rrdy;
        for (int i = 0; i < N; i++) begin
            req_addr_in[i*AW +: AW] = $urandom;
            req_data_in[i*DW +: DW] = {$urandom, $urandom};
            req_tag_in[i*TW +: TW]  = TW'($urandom);
        end
        k = -1;
        if (rsp_en && !rst && mem_out.size() != 0) begin
            k             = $urandom_range(mem_out.size() - 1);
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = mem_out[k];
            mem_rsp_data  = {$urandom, $urandom};
            r.idx         = int'(mem_out[k][SB-1:0]);
            r.tag         = mem_out[k][MTW-1:SB];
            r.data        = mem_rsp_data;
            r.ready       = rrdy[r.idx];
            rsp_q.push_back(r);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_tag   = MTW'($urandom);
            mem_rsp_data  = {$urandom, $urandom};
        end
        #1;
        if (rst) begin
            mon_en = 1'b0;
            exp_q.delete();
            rsp_q.delete();
            mem_out.delete();
            ptr = 0;
            for (int i = 0; i < N; i++) pend[i] = 0;
            #2;
            return;
        end
        mon_en = 1'b1;
        any_p = 1'b0;
        for (int i = 0; i < N; i++) if (pend[i] != 0) any_p = 1'b1;
        chk("busy", busy, (exp_q.size() != 0) || any_p);
        for (int i = 0; i < N; i++) eg[i] = v[i] && !(rw[i] == 1'b0 && pend[i] == MP);
        g = -1;
        if (exp_q.size() == 0 || mrdy) begin
            for (int j = 0; j < N; j++) begin
                int c = (ptr + j) % N;
                if (g < 0 && eg[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready_in", req_ready_in, exp_rdy);
        if (g >= 0) begin
            e.rw   = rw[g];
            e.addr = req_addr_in[g*AW +: AW];
            e.data = req_data_in[g*DW +: DW];
            e.tag  = {req_tag_in[g*TW +: TW], SB'(g)};
            ptr    = (g + 1) % N;
            if (!rw[g]) pend[g]++;
        end
        if (k >= 0) begin
            ridx = int'(mem_out[k][SB-1:0]);
            if (rrdy[ridx]) begin
                pend[ridx]--;
                mem_out.delete(k);
            end
        end
        #2;
        if (g >= 0) exp_q.push_back(e);
    endtask

    // Monitor: compares the registered stage and the routed response every cycle.
    initial begin
        rsp_t         r;
        logic [N-1:0] exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("mem_req_valid", mem_req_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    if (mem_req_valid) begin
                        chk("mem_req_rw", mem_req_rw, exp_q[0].rw);
                        chk("mem_req_addr", mem_req_addr, exp_q[0].addr);
                        chk("mem_req_data", mem_req_data, exp_q[0].data);
                        chk("mem_req_tag", mem_req_tag, exp_q[0].tag);
                    end
                    if (mem_req_ready) begin
                        if (!exp_q[0].rw) mem_out.push_back(exp_q[0].tag);
                        void'(exp_q.pop_front());
                    end
                end
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    exp_v = '0;
                    exp_v[r.idx] = 1'b1;
                    chk("rsp_valid_out", rsp_valid_out, exp_v);
                    chk("rsp_tag_out", rsp_tag_out, r.tag);
                    chk("rsp_data_out", rsp_data_out, r.data);
                    chk("mem_rsp_ready", mem_rsp_ready, r.ready);
                end else begin
                    chk("rsp_valid_idle", rsp_valid_out, '0);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20; i++) cycle(0, 2'b00, 2'b00, 1, 1, 2'b11);
    endtask

    initial begin
        reset = 1'b1;
        req_valid_in = '0; req_rw_in = '0; req_addr_in = '0; req_data_in = '0; req_tag_in = '0;
        rsp_ready_out = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_data = '0; mem_rsp_tag = '0;
        cycle(1, 2'b00, 2'b00, 0, 0, 2'b00);
        cycle(1, 2'b00, 2'b00, 0, 0, 2'b00);
        // reset state, then a single read from input 0 and its response
        cycle(0, 2'b00, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        for (int i = 0; i < 4; i++) cycle(0, 2'b00, 2'b00, 1, 1, 2'b11);
        // fairness: both inputs writing continuously
        for (int i = 0; i < 100; i++) cycle(0, 2'b11, 2'b11, 1, 0, 2'b11);
        // backpressure for five cycles, then release
        for (int i = 0; i < 5; i++) cycle(0, 2'b11, 2'b11, 0, 0, 2'b11);
        for (int i = 0; i < 4; i++) cycle(0, 2'b11, 2'b11, 1, 0, 2'b11);
        drain();
        // read cap on input 0; input 1 still served; a write at the cap passes
        for (int i = 0; i < 3; i++) cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b11, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b01, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        for (int i = 0; i < 4; i++) cycle(0, 2'b01, 2'b00, 1, 1, 2'b11);
        drain();
        // reset with three reads outstanding and the stage held
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b10, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b11, 2'b11, 0, 0, 2'b11);
        cycle(1, 2'b00, 2'b00, 0, 0, 2'b00);
        cycle(0, 2'b11, 2'b11, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        cycle(0, 2'b01, 2'b00, 1, 0, 2'b11);
        drain();
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(0, N'($urandom), N'($urandom), $urandom_range(9) < 7,
                  $urandom_range(1) == 1, N'($urandom));
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
